// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// interval_timer : tick-driven countdown timer fed by a divided-clock level
// Rev 1.0
// ============================================================================
module interval_timer #(
  parameter int VALUE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_clk,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [VALUE_W-1:0] ONE = VALUE_W'(1);

  state_t             state;
  logic [VALUE_W-1:0] count;
  logic               new_clk_d;
  logic               tick;

  // new_clk is treated as data; one tick per rising level transition
  assign tick = new_clk & ~new_clk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      new_clk_d <= 1'b1;
      expired   <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      new_clk_d <= new_clk;
      // a start wins over any same-cycle tick in every state
      if (start_timer) begin
        if (value != '0) begin
          state     <= S_RUN;
          count     <= value;
          expired   <= 1'b0;
          busy      <= 1'b1;
          remaining <= value;
        end else begin
          state     <= S_DONE;
          count     <= '0;
          expired   <= 1'b1;
          busy      <= 1'b0;
          remaining <= '0;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (tick) begin
              if (count > ONE) begin
                count     <= count - ONE;
                remaining <= count - ONE;
              end else begin
                state     <= S_DONE;
                count     <= '0;
                expired   <= 1'b1;
                busy      <= 1'b0;
                remaining <= '0;
              end
            end
          end
          S_DONE: begin
            expired   <= 1'b1;
            busy      <= 1'b0;
            remaining <= '0;
          end
          default: begin
            state     <= S_IDLE;
            expired   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// tb_interval_timer : scoreboard bench for interval_timer
// Rev 1.0
// ============================================================================
module tb_interval_timer;

  localparam int VALUE_W = 4;

  logic               clk;
  logic               reset;
  logic               new_clk;
  logic               start_timer;
  logic [VALUE_W-1:0] value;
  logic               expired;
  logic               busy;
  logic [VALUE_W-1:0] remaining;

  interval_timer #(.VALUE_W(VALUE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .new_clk     (new_clk),
    .start_timer (start_timer),
    .value       (value),
    .expired     (expired),
    .busy        (busy),
    .remaining   (remaining)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    logic       exp_expired;
    logic       exp_busy;
    logic [3:0] exp_remaining;
  } sb_item_t;

  sb_item_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_state = 0;   // 0 idle, 1 run, 2 done
  int m_count = 0;
  bit m_nd    = 1'b1;

  int  ph        = 0;  // new_clk phase: high 2 cycles, low 2 cycles
  int  nc_mode   = 0;  // 0 periodic, 1 forced high, 2 forced low
  bit  prev_nc   = 1'b0;
  int  tick_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drive one cycle, predict the post-edge outputs, compare after the edge
  task automatic cycle(input bit r, input bit s, input int v);
    bit nc;
    bit tk;
    sb_item_t it;
    sb_item_t got;
    case (nc_mode)
      1:       nc = 1'b1;
      2:       nc = 1'b0;
      default: nc = ((ph % 4) < 2);
    endcase
    ph++;
    reset       = r;
    start_timer = s;
    value       = v[VALUE_W-1:0];
    new_clk     = nc;

    tk = nc && !m_nd;
    if (r) begin
      m_state = 0; m_count = 0; m_nd = 1'b1;
    end else begin
      m_nd = nc;
      if (s) begin
        tick_cnt = 0;
        if (v != 0) begin m_state = 1; m_count = v; end
        else        begin m_state = 2; m_count = 0; end
      end else if (m_state == 1 && tk) begin
        tick_cnt++;
        if (m_count == 1) begin m_state = 2; m_count = 0; end
        else m_count = m_count - 1;
      end
    end
    prev_nc = nc;
    it.exp_expired   = (m_state == 2);
    it.exp_busy      = (m_state == 1);
    it.exp_remaining = (m_state == 1) ? m_count[3:0] : 4'd0;
    sb_q.push_back(it);

    @(posedge clk);
    @(negedge clk);
    got = sb_q.pop_front();
    check("sb_expired",   {31'd0, expired},   {31'd0, got.exp_expired});
    check("sb_busy",      {31'd0, busy},      {31'd0, got.exp_busy});
    check("sb_remaining", {28'd0, remaining}, {28'd0, got.exp_remaining});
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (m_state != 2 && n < budget) begin
      cycle(0, 0, 0);
      n++;
    end
    check("expiry_timeout", {31'd0, (m_state == 2)}, 32'd1);
  endtask

  task automatic run_until_count(input int target, input bit need_rise_next, input int budget);
    int n;
    n = 0;
    while (!(m_state == 1 && m_count == target &&
             (!need_rise_next || (ph % 4) == 0)) && n < budget) begin
      cycle(0, 0, 0);
      n++;
    end
    check("count_timeout", m_count, target);
  endtask

  initial begin
    reset = 1'b1; start_timer = 1'b0; value = '0; new_clk = 1'b0;

    // reset held two cycles
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("rst_expired", {31'd0, expired}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_rem",     {28'd0, remaining}, 32'd0);

    // basic countdown
    cycle(0, 1, 3);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_rem",  {28'd0, remaining}, 32'd3);
    run_until_done(40);
    check("basic_ticks", tick_cnt, 3);
    check("basic_busy_off", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0);
    check("basic_hold", {31'd0, expired}, 32'd1);

    // zero interval from idle
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    check("zero_expired", {31'd0, expired}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    cycle(0, 1, 2);
    check("zero_restart_exp", {31'd0, expired}, 32'd0);
    check("zero_restart_rem", {28'd0, remaining}, 32'd2);

    // restart mid-run
    cycle(1, 0, 0);
    cycle(0, 1, 5);
    run_until_count(3, 1'b0, 40);
    cycle(0, 1, 2);
    check("restart_rem", {28'd0, remaining}, 32'd2);
    run_until_done(40);
    check("restart_ticks", tick_cnt, 2);

    // start coinciding with a tick
    cycle(0, 1, 7);
    run_until_count(4, 1'b1, 40);
    check("collide_prev_low", {31'd0, prev_nc}, 32'd0);
    cycle(0, 1, 6);
    check("collide_rem", {28'd0, remaining}, 32'd6);
    run_until_done(60);
    check("collide_ticks", tick_cnt, 6);

    // max interval
    cycle(0, 1, 15);
    check("max_rem", {28'd0, remaining}, 32'd15);
    run_until_done(100);
    check("max_ticks", tick_cnt, 15);

    // reset mid-operation with new_clk held high
    cycle(0, 1, 5);
    run_until_count(3, 1'b0, 40);
    nc_mode = 1;
    cycle(1, 0, 0);
    check("midrst_exp",  {31'd0, expired}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rem",  {28'd0, remaining}, 32'd0);
    cycle(0, 1, 2);
    check("level_start_rem", {28'd0, remaining}, 32'd2);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("level_no_dec", {28'd0, remaining}, 32'd2);
    nc_mode = 2;
    cycle(0, 0, 0);
    nc_mode = 1;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("level_one_dec", {28'd0, remaining}, 32'd1);
    check("level_busy", {31'd0, busy}, 32'd1);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
